// File: rtl/alu_pkg.sv
// Shared definitions for the alu_seq block: opcodes, FSM state and flag bundle.
package alu_pkg;

    localparam logic [3:0] OP_AND  = 4'd0;
    localparam logic [3:0] OP_OR   = 4'd1;
    localparam logic [3:0] OP_ADD  = 4'd2;
    localparam logic [3:0] OP_SUB  = 4'd3;
    localparam logic [3:0] OP_SLT  = 4'd4;
    localparam logic [3:0] OP_SGE  = 4'd5;
    localparam logic [3:0] OP_EQ   = 4'd6;
    localparam logic [3:0] OP_XOR  = 4'd7;
    localparam logic [3:0] OP_SLL  = 4'd8;
    localparam logic [3:0] OP_SRL  = 4'd9;
    localparam logic [3:0] OP_SRA  = 4'd10;
    localparam logic [3:0] OP_SLTU = 4'd11;
    localparam logic [3:0] OP_MUL  = 4'd12;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } alu_state_t;

    typedef struct packed {
        logic zero;
        logic neg;
        logic carry;
        logic ovf;
        logic err;
    } alu_flags_t;

    // An empty output register reads as a zero result with no other flags.
    localparam alu_flags_t FLAGS_RST = alu_flags_t'(5'b10000);

endpackage

// File: rtl/alu_mul_serial.sv
// Serial shift-add multiplier: one partial-product step per cycle, WIDTH steps.
// done pulses combinationally during the last step; product is the final
// accumulator value valid in that same cycle.
module alu_mul_serial #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] product
);
    localparam int SHW = $clog2(WIDTH);
    localparam logic [SHW-1:0] LAST = SHW'(WIDTH - 1);

    logic             busy;
    logic [SHW-1:0]   cnt;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_nxt;

    assign acc_nxt = acc + (mplier[0] ? mcand : '0);
    assign product = acc_nxt;
    assign done    = busy && (cnt == LAST);

    // Iteration control: reset abandons any multiply in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= 1'b0;
            cnt  <= '0;
        end else if (start) begin
            busy <= 1'b1;
            cnt  <= '0;
        end else if (busy) begin
            if (cnt == LAST) begin
                busy <= 1'b0;
            end
            cnt <= cnt + 1'b1;
        end
    end

    // Datapath: operands captured on start, then shifted one bit per step.
    always_ff @(posedge clk) begin
        if (start) begin
            mcand  <= a;
            mplier <= b;
            acc    <= '0;
        end else if (busy) begin
            acc    <= acc_nxt;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Handshaked ALU with a registered result/flag stage.
// Define ALU_MUL_EN to compile in the serial multiplier (opcode 12, BUSY state);
// without it opcode 12 is reported as unsupported.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       alu_control,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             zero_flag,
    output logic             neg_flag,
    output logic             carry_flag,
    output logic             ovf_flag,
    output logic             op_err
);
    localparam int SHW = $clog2(WIDTH);

    alu_state_t        state;
    logic              accept;
    logic signed [WIDTH-1:0] a_s;
    logic signed [WIDTH-1:0] b_s;
    logic [SHW-1:0]    shamt;
    logic              is_sub;
    logic [WIDTH-1:0]  b_op;
    logic [WIDTH:0]    sum_p0;
    logic              ovf_p0;
    logic [WIDTH-1:0]  res_p0;
    logic              carry_p0;
    logic              vflag_p0;
    logic              err_p0;
    alu_flags_t        flags_p0;
    logic [WIDTH-1:0]  out_p1;
    alu_flags_t        flags_p1;
    logic              vld_p1;

    function automatic logic [WIDTH-1:0] bool_ext(input logic c);
        return {{(WIDTH-1){1'b0}}, c};
    endfunction

    function automatic alu_flags_t make_flags(input logic [WIDTH-1:0] r,
                                              input logic c, input logic v,
                                              input logic e);
        alu_flags_t f;
        f.zero  = (r == '0);
        f.neg   = r[WIDTH-1];
        f.carry = c;
        f.ovf   = v;
        f.err   = e;
        return f;
    endfunction

    assign accept   = in_valid && in_ready;
    assign in_ready = (state == ST_IDLE) && (!vld_p1 || out_ready);

    assign a_s    = a;
    assign b_s    = b;
    assign shamt  = b[SHW-1:0];
    assign is_sub = (alu_control == OP_SUB);
    // SUB is a + ~b + 1, so carry out means "no borrow".
    assign b_op   = is_sub ? ~b : b;
    assign sum_p0 = {1'b0, a} + {1'b0, b_op} + {{WIDTH{1'b0}}, is_sub};
    assign ovf_p0 = (a[WIDTH-1] == b_op[WIDTH-1]) && (sum_p0[WIDTH-1] != a[WIDTH-1]);

    // Stage p0: single-cycle operation decode and evaluation.
    always_comb begin
        res_p0   = '0;
        carry_p0 = 1'b0;
        vflag_p0 = 1'b0;
        err_p0   = 1'b0;
        case (alu_control)
            OP_AND:  res_p0 = a & b;
            OP_OR:   res_p0 = a | b;
            OP_ADD, OP_SUB: begin
                res_p0   = sum_p0[WIDTH-1:0];
                carry_p0 = sum_p0[WIDTH];
                vflag_p0 = ovf_p0;
            end
            OP_SLT:  res_p0 = bool_ext(a_s < b_s);
            OP_SGE:  res_p0 = bool_ext(a_s >= b_s);
            OP_EQ:   res_p0 = bool_ext(a == b);
            OP_XOR:  res_p0 = a ^ b;
            OP_SLL:  res_p0 = a << shamt;
            OP_SRL:  res_p0 = a >> shamt;
            OP_SRA:  res_p0 = a_s >>> shamt;
            OP_SLTU: res_p0 = bool_ext(a < b);
`ifdef ALU_MUL_EN
            OP_MUL:  res_p0 = '0;
`endif
            default: err_p0 = 1'b1;
        endcase
        flags_p0 = make_flags(res_p0, carry_p0, vflag_p0, err_p0);
    end

`ifdef ALU_MUL_EN
    logic             mul_start;
    logic             mul_done;
    logic [WIDTH-1:0] mul_res;

    assign mul_start = accept && (alu_control == OP_MUL);

    alu_mul_serial #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (mul_start),
        .a       (a),
        .b       (b),
        .done    (mul_done),
        .product (mul_res)
    );
`endif

    // Stage p1: FSM plus output register; retire and reload share one edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            vld_p1   <= 1'b0;
            out_p1   <= '0;
            flags_p1 <= FLAGS_RST;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
`ifdef ALU_MUL_EN
                        if (alu_control == OP_MUL) begin
                            state  <= ST_BUSY;
                            vld_p1 <= 1'b0;
                        end else
`endif
                        begin
                            out_p1   <= res_p0;
                            flags_p1 <= flags_p0;
                            vld_p1   <= 1'b1;
                        end
                    end else if (out_ready) begin
                        vld_p1 <= 1'b0;
                    end
                end
                ST_BUSY: begin
`ifdef ALU_MUL_EN
                    if (mul_done) begin
                        state    <= ST_IDLE;
                        out_p1   <= mul_res;
                        flags_p1 <= make_flags(mul_res, 1'b0, 1'b0, 1'b0);
                        vld_p1   <= 1'b1;
                    end
`else
                    state <= ST_IDLE;
`endif
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign out_valid  = vld_p1;
    assign out        = out_p1;
    assign zero_flag  = flags_p1.zero;
    assign neg_flag   = flags_p1.neg;
    assign carry_flag = flags_p1.carry;
    assign ovf_flag   = flags_p1.ovf;
    assign op_err     = flags_p1.err;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq (WIDTH=32); covers the multiplier when ALU_MUL_EN is defined.
module tb_alu_seq;
    import alu_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic [3:0]   alu_control = 4'd0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] out;
    logic         zero_flag, neg_flag, carry_flag, ovf_flag, op_err;
    logic [4:0]   flags;

    int checks = 0;
    int failures = 0;

    // flags packed as {zero, neg, carry, ovf, err}
    typedef struct {
        logic [3:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] y;
        logic [4:0]   f;
    } vec_t;

    vec_t vq[$];

    alu_seq #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .a           (a),
        .b           (b),
        .alu_control (alu_control),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out         (out),
        .zero_flag   (zero_flag),
        .neg_flag    (neg_flag),
        .carry_flag  (carry_flag),
        .ovf_flag    (ovf_flag),
        .op_err      (op_err)
    );

    assign flags = {zero_flag, neg_flag, carry_flag, ovf_flag, op_err};

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    function automatic void add_v(input logic [3:0] op, input logic [W-1:0] va,
                                  input logic [W-1:0] vb, input logic [W-1:0] y,
                                  input logic [4:0] f);
        vec_t v;
        v.op = op; v.a = va; v.b = vb; v.y = y; v.f = f;
        vq.push_back(v);
    endfunction

    task automatic present(input logic [3:0] op, input logic [W-1:0] va, input logic [W-1:0] vb);
        in_valid    = 1'b1;
        alu_control = op;
        a           = va;
        b           = vb;
    endtask

`ifdef ALU_MUL_EN
    task automatic run_mul(input string name, input logic [W-1:0] va,
                           input logic [W-1:0] vb, input logic [W-1:0] y);
        int early;
        early = 0;
        out_ready = 1'b1;
        present(OP_MUL, va, vb);
        @(posedge clk); #1;
        // operands must be ignored after accept
        present(OP_ADD, 32'h1234, 32'h5678);
        in_valid = 1'b0;
        for (int k = 1; k < W; k++) begin
            if (in_ready !== 1'b0 || out_valid !== 1'b0) early++;
            @(posedge clk); #1;
        end
        if (in_ready !== 1'b0 || out_valid !== 1'b0) early++;
        chk({name, "_busy_window"}, 64'(early), 64'd0);
        @(posedge clk); #1;
        chk({name, "_valid"}, {63'd0, out_valid}, 64'd1);
        chk({name, "_out"}, 64'(out), 64'(y));
        chk({name, "_in_ready"}, {63'd0, in_ready}, 64'd1);
    endtask
`endif

    initial begin
        // ops 0..7 with a=3, b=2, back to back
        add_v(OP_AND, 3, 2, 32'd2, 5'b00000);
        add_v(OP_OR,  3, 2, 32'd3, 5'b00000);
        add_v(OP_ADD, 3, 2, 32'd5, 5'b00000);
        add_v(OP_SUB, 3, 2, 32'd1, 5'b00100);
        add_v(OP_SLT, 3, 2, 32'd0, 5'b10000);
        add_v(OP_SGE, 3, 2, 32'd1, 5'b00000);
        add_v(OP_EQ,  3, 2, 32'd0, 5'b10000);
        add_v(OP_XOR, 3, 2, 32'd1, 5'b00000);
        // arithmetic boundaries
        add_v(OP_ADD, 32'h7FFFFFFF, 32'h1, 32'h80000000, 5'b01010);
        add_v(OP_SUB, 32'h0, 32'h1, 32'hFFFFFFFF, 5'b01000);
        add_v(OP_ADD, 32'hFFFFFFFF, 32'h1, 32'h0, 5'b10100);
        add_v(OP_SUB, 32'h80000000, 32'h1, 32'h7FFFFFFF, 5'b00110);
        add_v(OP_EQ,  32'hDEADBEEF, 32'hDEADBEEF, 32'h1, 5'b00000);
        // shifts: only b[4:0] = 1 is used
        add_v(OP_SRA, 32'h80000000, 32'h21, 32'hC0000000, 5'b01000);
        add_v(OP_SRL, 32'h80000000, 32'h21, 32'h40000000, 5'b00000);
        add_v(OP_SLL, 32'h80000000, 32'h21, 32'h0, 5'b10000);
        add_v(OP_SLL, 32'h00000003, 32'h24, 32'h30, 5'b00000);
        add_v(OP_SLTU, 32'h1, 32'hFFFFFFFF, 32'h1, 5'b00000);
        add_v(OP_SLT,  32'h1, 32'hFFFFFFFF, 32'h0, 5'b10000);
        add_v(OP_SGE,  32'h1, 32'hFFFFFFFF, 32'h1, 5'b00000);
        // reserved opcodes
        add_v(4'd13, 32'h5, 32'h6, 32'h0, 5'b10001);
        add_v(4'd15, 32'h5, 32'h6, 32'h0, 5'b10001);
        add_v(OP_OR, 32'hF0, 32'h0F, 32'hFF, 5'b00000);
`ifndef ALU_MUL_EN
        add_v(OP_MUL, 32'h7, 32'h6, 32'h0, 5'b10001);
        add_v(OP_AND, 32'hFFFF0000, 32'hFF00FF00, 32'hFF000000, 5'b01000);
`endif

        // reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_out", 64'(out), 64'd0);
        chk("rst_flags", 64'(flags), 64'(5'b10000));
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
        @(negedge clk);
        rst_n = 1'b1;

        // table: one result per cycle, no bubbles
        for (int i = 0; i < vq.size(); i++) begin
            present(vq[i].op, vq[i].a, vq[i].b);
            @(posedge clk); #1;
            chk($sformatf("vec%0d_op%0d_out", i, vq[i].op), 64'(out), 64'(vq[i].y));
            chk($sformatf("vec%0d_op%0d_flags", i, vq[i].op), 64'(flags), 64'(vq[i].f));
            chk($sformatf("vec%0d_valid", i), {63'd0, out_valid}, 64'd1);
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk("drain_valid", {63'd0, out_valid}, 64'd0);

        // backpressure: result must stay put while the consumer stalls
        out_ready = 1'b0;
        present(OP_ADD, 32'h7FFFFFFF, 32'h7FFFFFFF);
        @(posedge clk); #1;
        present(OP_XOR, 32'hF0, 32'h0F);
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("bp%0d_out", k), 64'(out), 64'(32'hFFFFFFFE));
            chk($sformatf("bp%0d_flags", k), 64'(flags), 64'(5'b01010));
            chk($sformatf("bp%0d_valid", k), {63'd0, out_valid}, 64'd1);
            chk($sformatf("bp%0d_in_ready", k), {63'd0, in_ready}, 64'd0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_in_ready", {63'd0, in_ready}, 64'd1);
        @(posedge clk); #1;
        chk("bp_reload_out", 64'(out), 64'(32'hFF));
        chk("bp_reload_valid", {63'd0, out_valid}, 64'd1);
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk("bp_retire_valid", {63'd0, out_valid}, 64'd0);

`ifdef ALU_MUL_EN
        run_mul("mul_7x6", 32'd7, 32'd6, 32'd42);
        run_mul("mul_ffx3", 32'hFFFFFFFF, 32'd3, 32'hFFFFFFFD);
        // reset in the middle of a multiply
        present(OP_MUL, 32'd7, 32'd6);
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", {63'd0, out_valid}, 64'd0);
        chk("midrst_in_ready", {63'd0, in_ready}, 64'd1);
        chk("midrst_flags", 64'(flags), 64'(5'b10000));
        @(negedge clk);
        rst_n = 1'b1;
        present(OP_ADD, 32'd4, 32'd5);
        @(posedge clk); #1;
        chk("postrst_out", 64'(out), 64'd9);
        chk("postrst_valid", {63'd0, out_valid}, 64'd1);
        in_valid = 1'b0;
        run_mul("mul_after_rst", 32'd7, 32'd6, 32'd42);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, handshaked ALU with registered outputs and status flags. Executes single-cycle logic, arithmetic, compare and shift operations with one-cycle latency. An optional serial shift-add multiplier adds a multi-cycle operation. Sits between the decode stage and the writeback register; both sides use valid/ready handshakes, so either side can stall the block.

## Interface
- WIDTH, 32, operand and result width; power of two, minimum 4
- SHW, $clog2(WIDTH), shift-amount width; derived, not overridable
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operand/opcode presented
- in_ready  output  1  block accepts operands this cycle
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- alu_control  input  4  opcode
- out_valid  output  1  result/flags valid
- out_ready  input  1  consumer accepts the result
- out  output  WIDTH  result
- zero_flag  output  1  out == 0
- neg_flag  output  1  out[WIDTH-1]
- carry_flag  output  1  carry out of ADD; NOT borrow for SUB; 0 otherwise
- ovf_flag  output  1  signed overflow for ADD/SUB; 0 otherwise
- op_err  output  1  opcode unsupported

## Operation
- Opcodes: 0 AND, 1 OR, 2 ADD, 3 SUB, 4 SLT signed, 5 SGE signed, 6 EQ, 7 XOR, 8 SLL, 9 SRL, 10 SRA, 11 SLTU, 12 MUL (low WIDTH bits of the product), 13–15 reserved.
- Compares produce 1 or 0, zero-extended to WIDTH.
- Shifts use b[SHW-1:0]; the upper bits of b are ignored.
- ADD/SUB are computed in WIDTH+1 bits. carry is bit WIDTH. ovf = (sign a == sign b') && (sign result != sign a), where b' = ~b for SUB.
- Unsupported or reserved opcode: out = 0, zero_flag = 1, op_err = 1. Latency is one cycle.
- FSM states:
  - IDLE: single-cycle ops complete here.
  - BUSY: multiplier iterating.
  - Transitions: IDLE→BUSY on accept of MUL. BUSY→IDLE when the iteration count reaches WIDTH, with the result written into the output register.
- Output register holds out and all flags stable while out_valid=1 and out_ready=0.
- in_ready = (state==IDLE) && (!out_valid || out_ready).
- Simultaneous out_ready and new accept: the old result retires and the new result loads on the same edge, with no bubble.
- Reset (any time, including mid-MUL):
  - state=IDLE, out_valid=0, out=0.
  - zero_flag=1, all other flags 0.
  - Iteration counter cleared; the partial product is discarded.

## Timing
- Accept = rising edge with in_valid && in_ready.
- Single-cycle ops: out_valid=1 after the accept edge, i.e. latency 1. Full throughput of one op per cycle while out_ready=1.
- MUL:
  - in_ready=0 for WIDTH cycles after accept.
  - out_valid rises on the WIDTH-th edge after the accept edge.
  - in_ready returns high in the same cycle that out_valid rises, provided out_ready=1.
- out_valid falls on the edge where out_ready=1 and no new accept occurs.
- Inputs a, b and alu_control are sampled only at accept. Changes afterwards have no effect.

## Configuration
- ALU_MUL_EN defined:
  - Opcode 12 is supported.
  - The serial multiplier and the BUSY state are compiled in.
- ALU_MUL_EN undefined:
  - Opcode 12 is treated as unsupported: op_err=1, one-cycle latency.
  - BUSY is unreachable and in_ready depends only on the output register.

## Structure
- Package alu_pkg:
  - Opcode localparams (OP_AND … OP_MUL).
  - FSM state enum.
  - Flag-bundle typedef.
- Sub-module alu_mul_serial (WIDTH parameter): start/done interface plus an internal counter. It is instantiated only under ALU_MUL_EN.
- All combinational op logic lives in the top level.

## Test plan
- WIDTH=32, a=3, b=2, ops 0–7 back-to-back with out_ready=1. Required out values: 2, 3, 5, 1, 0, 1, 0, 1, one per cycle with no bubbles.
- ADD a=0x7FFFFFFF, b=1 → out=0x80000000, ovf=1, neg=1, carry=0. SUB a=0, b=1 → out=0xFFFFFFFF, carry=0, ovf=0. ADD a=0xFFFFFFFF, b=1 → out=0, zero=1, carry=1.
- Shifts with a=0x80000000, b=0x21:
  - SRA → 0xC0000000.
  - SRL → 0x40000000.
  - SLTU a=1, b=0xFFFFFFFF → 1; SLT with the same operands → 0.
- Backpressure: hold out_ready=0 for 5 cycles after a result. Required: out and flags stable, in_ready=0. Raise out_ready together with in_valid: the next result loads on the same edge.
- ALU_MUL_EN defined, MUL a=7, b=6:
  - in_ready low for 32 cycles.
  - out=42 appears 32 edges after accept.
  - Assert rst_n=0 mid-MUL in a repeat run: out_valid=0 immediately, and the next op after reset completes normally.
- ALU_MUL_EN undefined, opcode 12 or 15 → out=0, op_err=1, zero_flag=1, latency 1.
